// File: rtl/spram_cfg.sv
// ---------------------------------------------------------------------------
// spram_cfg - parametrised single-port synchronous RAM tile primitive.
//
// Successor to the fixed 2Kx8 SPRAM benchmark. Width, depth and byte-lane
// width are configurable. Writes are masked per byte lane. The read-during-
// write behaviour is selectable, and an optional output register adds a
// second pipeline stage. A clear engine can fill the whole array with
// CLEAR_VAL after reset.
//
// Parameters
//   DATA_W      word width (multiple of BYTE_W)
//   ADDR_W      address width, depth = 2**ADDR_W
//   BYTE_W      byte-lane width, NB = DATA_W/BYTE_W lanes
//   WRITE_MODE  0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE
//   OUT_REG     0 = read latency 1, 1 = read latency 2
//   CLEAR_EN    1 = fill array with CLEAR_VAL after reset
//   CLEAR_VAL   fill value used by the clear engine
//
// Ports
//   clk           clock, all state on the rising edge
//   rst           asynchronous active-high reset
//   en            access enable
//   write_enable  1 = write, 0 = read (qualified by en)
//   byte_en       per-lane write mask
//   addr          word address
//   write_data    write data
//   read_data     read data (registered)
//   read_valid    one-cycle pulse aligned with new read_data
//   busy          high in reset and while clearing; user accesses ignored
// ---------------------------------------------------------------------------
module spram_cfg #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 11,
    parameter int                BYTE_W     = 8,
    parameter int                WRITE_MODE = 0,
    parameter int                OUT_REG    = 0,
    parameter int                CLEAR_EN   = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = {DATA_W{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       write_enable,
    input  logic [DATA_W/BYTE_W-1:0]   byte_en,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          write_data,
    output logic [DATA_W-1:0]          read_data,
    output logic                       read_valid,
    output logic                       busy
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE   = 2;

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Without a clear engine the array is usable straight out of reset.
    localparam state_t RST_STATE = (CLEAR_EN != 0) ? ST_CLEAR : ST_READY;

    // Overlay the enabled lanes of new_w onto old_w.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                m[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
            end
        end
        return m;
    endfunction

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_s;

    logic              clr_wr_s;
    logic              usr_rd_s;
    logic              usr_wr_s;
    logic [DATA_W-1:0] old_word_s;
    logic [DATA_W-1:0] merged_s;

    logic [DATA_W-1:0] rd_data_r;
    logic [DATA_W-1:0] rd_data_s;
    logic              rd_valid_r;
    logic              rd_valid_s;
    logic              busy_r;

    // State and clear-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RST_STATE;
            cnt_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state: CLEAR walks every address once, then parks in READY.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_CLEAR: begin
                cnt_s = cnt_r + ADDR_W'(1'b1);
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_s = ST_READY;
                cnt_s   = cnt_r;
            end
            default: begin
                state_s = RST_STATE;
                cnt_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Access decode and read-stage next value.
    always_comb begin
        clr_wr_s   = (state_r == ST_CLEAR);
        usr_rd_s   = (state_r == ST_READY) && en && !write_enable;
        usr_wr_s   = (state_r == ST_READY) && en && write_enable;
        old_word_s = mem[addr];
        merged_s   = merge_lanes(old_word_s, write_data, byte_en);
        rd_data_s  = rd_data_r;
        rd_valid_s = 1'b0;
        if (usr_rd_s) begin
            rd_data_s  = old_word_s;
            rd_valid_s = 1'b1;
        end else if (usr_wr_s) begin
            case (WRITE_MODE)
                WM_READ_FIRST: begin
                    rd_data_s  = old_word_s;
                    rd_valid_s = 1'b1;
                end
                WM_WRITE_FIRST: begin
                    rd_data_s  = merged_s;
                    rd_valid_s = 1'b1;
                end
                WM_NO_CHANGE: begin
                    rd_data_s  = rd_data_r;
                    rd_valid_s = 1'b0;
                end
                default: begin
                    rd_data_s  = old_word_s;
                    rd_valid_s = 1'b1;
                end
            endcase
        end else begin
            rd_data_s  = rd_data_r;
            rd_valid_s = 1'b0;
        end
    end

    // Memory array: clear engine has priority, user writes only in READY.
    always_ff @(posedge clk) begin
        if (clr_wr_s) begin
            mem[cnt_r] <= CLEAR_VAL;
        end else if (usr_wr_s) begin
            mem[addr] <= merged_s;
        end
    end

    // First read stage and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            rd_data_r  <= rd_data_s;
            rd_valid_r <= rd_valid_s;
            busy_r     <= (state_s == ST_CLEAR);
        end
    end

    assign busy = busy_r;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] rd_data2_r;
            logic              rd_valid2_r;

            // Second output stage, loaded every cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data2_r  <= {DATA_W{1'b0}};
                    rd_valid2_r <= 1'b0;
                end else begin
                    rd_data2_r  <= rd_data_r;
                    rd_valid2_r <= rd_valid_r;
                end
            end

            assign read_data  = rd_data2_r;
            assign read_valid = rd_valid2_r;
        end else begin : g_no_out_reg
            assign read_data  = rd_data_r;
            assign read_valid = rd_valid_r;
        end
    endgenerate

endmodule

// File: tb/tb_spram_cfg.sv
// ---------------------------------------------------------------------------
// tb_spram_cfg - directed self-checking bench for spram_cfg.
// Five instances share clock, reset and access controls:
//   u_def  default parameters (READ_FIRST)
//   u_wf   WRITE_FIRST
//   u_nc   NO_CHANGE
//   u_w32  32-bit word, four byte lanes
//   u_or   output register enabled
// All instances have the same depth and clear together. The 8-bit instances
// therefore hold identical contents throughout.
// ---------------------------------------------------------------------------
module tb_spram_cfg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        we  = 1'b0;
    logic [10:0] addr = 11'h000;
    logic [7:0]  wd8  = 8'h00;
    logic        be1  = 1'b1;
    logic [31:0] wd32 = 32'h0;
    logic [3:0]  be4  = 4'h0;

    logic [7:0]  rd_def, rd_wf, rd_nc, rd_or;
    logic [31:0] rd_w32;
    logic        rv_def, rv_wf, rv_nc, rv_w32, rv_or;
    logic        busy_def, busy_wf, busy_nc, busy_w32, busy_or;

    int n_pass  = 0;
    int n_total = 0;
    int n_cyc;

    logic [10:0] t2_addr [6] = '{11'h000, 11'h008, 11'h080, 11'h200, 11'h400, 11'h401};

    always #5 clk = ~clk;

    spram_cfg u_def (
        .clk(clk), .rst(rst), .en(en), .write_enable(we), .byte_en(be1),
        .addr(addr), .write_data(wd8), .read_data(rd_def), .read_valid(rv_def),
        .busy(busy_def)
    );

    spram_cfg #(.WRITE_MODE(1)) u_wf (
        .clk(clk), .rst(rst), .en(en), .write_enable(we), .byte_en(be1),
        .addr(addr), .write_data(wd8), .read_data(rd_wf), .read_valid(rv_wf),
        .busy(busy_wf)
    );

    spram_cfg #(.WRITE_MODE(2)) u_nc (
        .clk(clk), .rst(rst), .en(en), .write_enable(we), .byte_en(be1),
        .addr(addr), .write_data(wd8), .read_data(rd_nc), .read_valid(rv_nc),
        .busy(busy_nc)
    );

    spram_cfg #(.DATA_W(32)) u_w32 (
        .clk(clk), .rst(rst), .en(en), .write_enable(we), .byte_en(be4),
        .addr(addr), .write_data(wd32), .read_data(rd_w32), .read_valid(rv_w32),
        .busy(busy_w32)
    );

    spram_cfg #(.OUT_REG(1)) u_or (
        .clk(clk), .rst(rst), .en(en), .write_enable(we), .byte_en(be1),
        .addr(addr), .write_data(wd8), .read_data(rd_or), .read_valid(rv_or),
        .busy(busy_or)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until busy drops, bounded so a stuck clear cannot hang.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_def && n < 4000);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_val("rst_rd", {24'h0, rd_def}, 32'h0);
        check_val("rst_rv", {31'h0, rv_def}, 32'h0);
        check_val("rst_busy", {31'h0, busy_def}, 32'h1);

        // T1: busy for exactly 2048 cycles after release
        rst = 1'b0;
        wait_ready(n_cyc);
        check_val("clear_len", n_cyc, 32'd2048);
        check_val("busy_all", {27'h0, busy_def, busy_wf, busy_nc, busy_w32, busy_or}, 32'h0);

        en = 1'b1; we = 1'b0; addr = 11'h000;
        tick();
        check_val("t1_rd000", {24'h0, rd_def}, 32'h0);
        check_val("t1_rv000", {31'h0, rv_def}, 32'h1);
        addr = 11'h7FF;
        tick();
        check_val("t1_rd7ff", {24'h0, rd_def}, 32'h0);
        check_val("t1_rv7ff", {31'h0, rv_def}, 32'h1);
        en = 1'b0;
        tick();
        check_val("t1_idle_rv", {31'h0, rv_def}, 32'h0);

        // T2: writes then back-to-back reads
        en = 1'b1; we = 1'b1; be1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            addr = t2_addr[i];
            wd8  = 8'(i);
            tick();
            check_val("t2_wr_old", {24'h0, rd_def}, 32'h0);
            check_val("t2_wr_rv", {31'h0, rv_def}, 32'h1);
        end
        we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            addr = t2_addr[i];
            tick();
            check_val("t2_rd", {24'h0, rd_def}, 32'(i));
            check_val("t2_rv", {31'h0, rv_def}, 32'h1);
        end

        // T4: overwrite 0x401, read-during-write per mode
        addr = 11'h200;
        tick();
        check_val("t4_nc_pre", {24'h0, rd_nc}, 32'h3);
        we = 1'b1; addr = 11'h401; wd8 = 8'h06;
        tick();
        check_val("t4_rf_rd", {24'h0, rd_def}, 32'h5);
        check_val("t4_rf_rv", {31'h0, rv_def}, 32'h1);
        check_val("t4_wf_rd", {24'h0, rd_wf}, 32'h6);
        check_val("t4_wf_rv", {31'h0, rv_wf}, 32'h1);
        check_val("t4_nc_rd", {24'h0, rd_nc}, 32'h3);
        check_val("t4_nc_rv", {31'h0, rv_nc}, 32'h0);
        we = 1'b0;
        tick();
        check_val("t4_raw_rf", {24'h0, rd_def}, 32'h6);
        check_val("t4_raw_nc", {24'h0, rd_nc}, 32'h6);
        check_val("t4_raw_ncv", {31'h0, rv_nc}, 32'h1);

        // T5: output register, latency 2 and hold
        en = 1'b0;
        tick();
        tick();
        en = 1'b1; addr = 11'h008;
        tick();
        check_val("t5_rv_e1", {31'h0, rv_or}, 32'h0);
        en = 1'b0;
        tick();
        check_val("t5_rd_e2", {24'h0, rd_or}, 32'h1);
        check_val("t5_rv_e2", {31'h0, rv_or}, 32'h1);
        tick();
        check_val("t5_rd_hold", {24'h0, rd_or}, 32'h1);
        check_val("t5_rv_hold", {31'h0, rv_or}, 32'h0);

        // T3: 32-bit lane merge and empty-mask no-op
        be1 = 1'b0;
        en = 1'b1; we = 1'b1; addr = 11'h010;
        wd32 = 32'hAABBCCDD; be4 = 4'b1111;
        tick();
        wd32 = 32'h11223344; be4 = 4'b0101;
        tick();
        wd32 = 32'hFFFFFFFF; be4 = 4'b0000;
        tick();
        we = 1'b0;
        tick();
        check_val("t3_merge", rd_w32, 32'hAA22CC44);
        check_val("t3_rv", {31'h0, rv_w32}, 32'h1);

        // T6: reset mid-access, then reset mid-clear restarts the clear
        addr = 11'h401;
        tick();
        check_val("t6_pre_rd", {24'h0, rd_def}, 32'h6);
        rst = 1'b1;
        #1;
        check_val("t6_rst_rd", {24'h0, rd_def}, 32'h0);
        check_val("t6_rst_rv", {31'h0, rv_def}, 32'h0);
        check_val("t6_rst_or", {24'h0, rd_or}, 32'h0);
        check_val("t6_rst_busy", {31'h0, busy_def}, 32'h1);
        tick();
        rst = 1'b0;
        repeat (100) tick();
        check_val("t6_busy100", {31'h0, busy_def}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n_cyc);
        check_val("t6_clear_len", n_cyc, 32'd2048);
        tick();
        check_val("t6_cleared", {24'h0, rd_def}, 32'h0);
        check_val("t6_cleared_v", {31'h0, rv_def}, 32'h1);
        en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
